// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP reply path (scheduler, request queue, encoder).
// ARP_BEATS depends on SPEED_100M.
package arp_pkg;

  typedef struct packed {
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARP_TX = 2'd1,
    APP_TX = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Encoder beats per reply; the 100M datapath is half as wide.
`ifdef SPEED_100M
  localparam int ARP_BEATS = 56;
`else
  localparam int ARP_BEATS = 28;
`endif

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

endpackage

// File: rtl/arp_req_fifo.sv
// Circular buffer of pending ARP reply requests.
// With ARP_DEDUP_EN it also reports which occupied entries hold a given tpa.
module arp_req_fifo
  import arp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  arp_req_t         data,
`ifdef ARP_DEDUP_EN
  input  logic [31:0]      match_tpa,
  output logic [DEPTH-1:0] tpa_match,
`endif
  output logic             full,
  output logic             empty,
  output arp_req_t         head
);

  localparam int AW = $clog2(DEPTH);

  arp_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  // The caller only pushes when not full and only pops when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

`ifdef ARP_DEDUP_EN
  logic [AW-1:0] offset;

  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    tpa_match = '0;
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = AW'(i) - rd_ptr;
      tpa_match[i] = ({1'b0, offset} < count) && (mem[i].tpa == match_tpa);
    end
  end
`endif

endmodule

// File: rtl/arp_tx_scheduler.sv
// Queues ARP reply requests, runs the encoder for one reply at a time and shares the
// TX path round-robin with the application source. Optional ARP_DEDUP_EN drops repeat tpas.
module arp_tx_scheduler
  import arp_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_req_valid,
  input  logic [47:0] arp_req_tha,
  input  logic [31:0] arp_req_tpa,
  output logic        arp_req_ready,
  output logic        enc_en,
  output logic [47:0] enc_tha,
  output logic [31:0] enc_tpa,
  input  logic        app_req,
  output logic        app_gnt,
  input  logic        app_done,
  output logic        tx_sel,
  output logic        tx_busy,
  output logic [15:0] drop_cnt
);

  localparam int BEAT_W = $clog2(ARP_BEATS);
  localparam int GAP_W  = $clog2(IFG_CYCLES + 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_arp;
  logic [BEAT_W-1:0] beat_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_beat;
  logic             gap_done;
  logic             pick_arp;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  arp_req_t         fifo_head;
  arp_req_t         push_data;

  // arp_req handshake: a request transfers on valid && ready; ready depends only on
  // the registered queue occupancy, never on a same-cycle pop.
  assign arp_req_ready  = !fifo_full;
  assign push_data.tha  = arp_req_tha;
  assign push_data.tpa  = arp_req_tpa;
  assign fifo_pop       = last_beat;

`ifdef ARP_DEDUP_EN
  logic [QUEUE_DEPTH-1:0] tpa_match;
  assign fifo_push = arp_req_valid && !fifo_full && !(|tpa_match);
`else
  assign fifo_push = arp_req_valid && !fifo_full;
`endif

  arp_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .data      (push_data),
`ifdef ARP_DEDUP_EN
    .match_tpa (arp_req_tpa),
    .tpa_match (tpa_match),
`endif
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign last_beat = (state == ARP_TX) && (beat_cnt == BEAT_W'(ARP_BEATS - 1));
  assign gap_done  = (state == GAP) && (gap_cnt == GAP_W'(IFG_CYCLES - 1));
  // On a tie the side not served last wins.
  assign pick_arp  = !fifo_empty && (!app_req || !last_arp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty || app_req) state_nxt = pick_arp ? ARP_TX : APP_TX;
      ARP_TX:  if (last_beat) state_nxt = GAP;
      APP_TX:  if (app_done) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    enc_en  = (state == ARP_TX);
    app_gnt = (state == APP_TX);
    tx_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      gap_cnt  <= '0;
      last_arp <= 1'b0;
      tx_sel   <= 1'b0;
      enc_tha  <= '0;
      enc_tpa  <= '0;
      drop_cnt <= '0;
    end else begin
      beat_cnt <= (state == ARP_TX && !last_beat) ? beat_cnt + 1'b1 : '0;
      gap_cnt  <= (state == GAP && !gap_done) ? gap_cnt + 1'b1 : '0;
      if (last_beat)                   last_arp <= 1'b1;
      else if (app_gnt && app_done)    last_arp <= 1'b0;
      if (state == IDLE && state_nxt == ARP_TX) begin
        tx_sel  <= 1'b0;
        enc_tha <= fifo_head.tha;
        enc_tpa <= fifo_head.tpa;
      end else if (state == IDLE && state_nxt == APP_TX) begin
        tx_sel  <= 1'b1;
      end
      if (arp_req_valid && fifo_full && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_arp_tx_scheduler.sv
// Directed bench for arp_tx_scheduler: stimulus queues expected frame records,
// a negedge monitor rebuilds each frame from the outputs and compares in order.
module tb_arp_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int IFG   = 12;
`ifdef SPEED_100M
  localparam int BEATS = 56;
`else
  localparam int BEATS = 28;
`endif
  // Frame record: {is_app, tha, tpa, length}
  localparam int RW = 97;

  logic        clk;
  logic        rst_n;
  logic        arp_req_valid;
  logic [47:0] arp_req_tha;
  logic [31:0] arp_req_tpa;
  logic        arp_req_ready;
  logic        enc_en;
  logic [47:0] enc_tha;
  logic [31:0] enc_tpa;
  logic        app_req;
  logic        app_gnt;
  logic        app_done;
  logic        tx_sel;
  logic        tx_busy;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  arp_tx_scheduler #(.QUEUE_DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arp_req_valid (arp_req_valid),
    .arp_req_tha   (arp_req_tha),
    .arp_req_tpa   (arp_req_tpa),
    .arp_req_ready (arp_req_ready),
    .enc_en        (enc_en),
    .enc_tha       (enc_tha),
    .enc_tpa       (enc_tpa),
    .app_req       (app_req),
    .app_gnt       (app_gnt),
    .app_done      (app_done),
    .tx_sel        (tx_sel),
    .tx_busy       (tx_busy),
    .drop_cnt      (drop_cnt)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [RW-1:0] rec(input logic app, input logic [47:0] tha,
                                        input logic [31:0] tpa, input int len);
    return {app, tha, tpa, 16'(len)};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [47:0] tha, input logic [31:0] tpa);
    arp_req_valid = 1'b1;
    arp_req_tha   = tha;
    arp_req_tpa   = tpa;
    @(posedge clk); #1;
    arp_req_valid = 1'b0;
  endtask

  task automatic app_frame(input int len);
    int t = 0;
    app_req = 1'b1;
    while (app_gnt !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("app_grant_wait", t < 1000, 1'b1);
    app_req = 1'b0;
    if (t < 1000) begin
      repeat (len - 1) @(posedge clk);
      #1 app_done = 1'b1;
      @(posedge clk); #1;
      app_done = 1'b0;
    end
  endtask

  task automatic wait_enc();
    int t = 0;
    while (enc_en !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("enc_start_wait", t < 500, 1'b1);
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((exp_q.size() != 0 || tx_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("quiet_wait", t < 3000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        in_arp, in_app, in_gap, hold_bad, overlap;
  int          run_len, gap_len;
  logic [47:0] cap_tha;
  logic [31:0] cap_tpa;

  task automatic end_frame(input logic [RW-1:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL frame: got %0h required no frame", got);
    end else begin
      check("frame", got, exp_q.pop_front());
    end
    check("frame_hold", hold_bad, 1'b0);
    check("exclusive", overlap, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      in_arp = 1'b0;
      in_app = 1'b0;
      in_gap = 1'b0;
    end else begin
      if (enc_en) begin
        if (!in_arp) begin
          in_arp = 1'b1; run_len = 0; hold_bad = 1'b0; overlap = 1'b0;
          cap_tha = enc_tha; cap_tpa = enc_tpa;
        end
        run_len++;
        if (enc_tha !== cap_tha || enc_tpa !== cap_tpa || tx_sel !== 1'b0) hold_bad = 1'b1;
      end else if (in_arp) begin
        in_arp = 1'b0;
        end_frame(rec(1'b0, cap_tha, cap_tpa, run_len));
        in_gap = 1'b1; gap_len = 0;
      end
      if (app_gnt) begin
        if (!in_app) begin
          in_app = 1'b1; run_len = 0; hold_bad = 1'b0; overlap = 1'b0;
        end
        run_len++;
        if (tx_sel !== 1'b1) hold_bad = 1'b1;
      end else if (in_app) begin
        in_app = 1'b0;
        end_frame(rec(1'b1, 48'h0, 32'h0, run_len));
        in_gap = 1'b1; gap_len = 0;
      end
      if (enc_en && app_gnt) overlap = 1'b1;
      if (in_gap) begin
        if (tx_busy && !enc_en && !app_gnt) gap_len++;
        else begin
          check("gap_len", gap_len, IFG);
          in_gap = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int enc_cycles;

  initial begin
    rst_n = 1'b0; arp_req_valid = 1'b0; arp_req_tha = '0; arp_req_tpa = '0;
    app_req = 1'b0; app_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enc_en", enc_en, 1'b0);
    check("rst_enc_tha", enc_tha, 48'h0);
    check("rst_enc_tpa", enc_tpa, 32'h0);
    check("rst_app_gnt", app_gnt, 1'b0);
    check("rst_tx_sel", tx_sel, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", arp_req_ready, 1'b1);

    // single reply
    exp_q.push_back(rec(1'b0, 48'h0A0B0C0D0E0F, 32'hC0A80001, BEATS));
    push_req(48'h0A0B0C0D0E0F, 32'hC0A80001);
    wait_quiet();

    // overflow while the app owns the path
    exp_q.push_back(rec(1'b1, 48'h0, 32'h0, 60));
    for (int i = 0; i < 4; i++)
      exp_q.push_back(rec(1'b0, 48'h1000 + 48'(i), 32'h0A000000 + 32'(i), BEATS));
    fork
      app_frame(60);
      begin
        while (app_gnt !== 1'b1) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          arp_req_valid = 1'b1;
          arp_req_tha   = 48'h1000 + 48'(i);
          arp_req_tpa   = 32'h0A000000 + 32'(i);
          @(negedge clk);
          check("ready_push", arp_req_ready, i < 4);
          @(posedge clk); #1;
        end
        arp_req_valid = 1'b0;
        @(negedge clk);
        check("drop_after_overflow", drop_cnt, 16'd1);
        check("ready_full", arp_req_ready, 1'b0);
      end
    join
    wait_quiet();

    // reset at beat 10 with a second request still queued
    push_req(48'hB1, 32'hB1);
    push_req(48'hB2, 32'hB2);
    wait_enc();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_enc_en", enc_en, 1'b0);
    check("abort_tx_busy", tx_busy, 1'b0);
    check("abort_drop_cnt", drop_cnt, 16'h0);
    check("abort_ready", arp_req_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    enc_cycles = 0;
    repeat (80) begin
      @(negedge clk);
      if (enc_en) enc_cycles++;
    end
    check("no_resume", enc_cycles, 0);
    check("idle_after_abort", tx_busy, 1'b0);
    @(posedge clk); #1;

    // round-robin from reset: ARP first, then alternate
    exp_q.push_back(rec(1'b0, 48'hA1, 32'hC0A800A1, BEATS));
    exp_q.push_back(rec(1'b1, 48'h0, 32'h0, 20));
    exp_q.push_back(rec(1'b0, 48'hA2, 32'hC0A800A2, BEATS));
    exp_q.push_back(rec(1'b1, 48'h0, 32'h0, 15));
    push_req(48'hA1, 32'hC0A800A1);
    fork
      begin
        app_frame(20);
        app_frame(15);
      end
      push_req(48'hA2, 32'hC0A800A2);
    join
    wait_quiet();

    // stray app_done during ARP_TX, then a 100-cycle app frame
    exp_q.push_back(rec(1'b0, 48'hA3, 32'hC0A800A3, BEATS));
    push_req(48'hA3, 32'hC0A800A3);
    wait_enc();
    @(posedge clk); #1 app_done = 1'b1;
    @(posedge clk); #1 app_done = 1'b0;
    wait_quiet();
    exp_q.push_back(rec(1'b1, 48'h0, 32'h0, 100));
    app_frame(100);
    wait_quiet();

    // duplicate tpa while the first copy is pending
    exp_q.push_back(rec(1'b0, 48'h55A, 32'hC0A80005, BEATS));
`ifndef ARP_DEDUP_EN
    exp_q.push_back(rec(1'b0, 48'h55B, 32'hC0A80005, BEATS));
`endif
    push_req(48'h55A, 32'hC0A80005);
    push_req(48'h55B, 32'hC0A80005);
    wait_quiet();
    check("dup_drop_cnt", drop_cnt, 16'h0);

    check("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arp_tx_scheduler.md
Name: arp_tx_scheduler

Overview:
- Sequences the ARP reply encoder (`arp_encode`) and shares the single Ethernet TX path between ARP replies and an application frame source.
- Queues pending reply requests (tha/tpa) from the ARP decoder.
- Drives encoder enable for exactly one reply length, then enforces an inter-frame gap.
- Arbitrates round-robin against the application source.

Parameters:
- QUEUE_DEPTH, 4, pending ARP request entries; power of 2, min 2.
- IFG_CYCLES, 12, idle cycles forced between any two frames; min 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- arp_req_valid  in  1  request to send one ARP reply
- arp_req_tha  in  48  target hardware address for that reply
- arp_req_tpa  in  32  target protocol address for that reply
- arp_req_ready  out  1  queue can accept; high when count < QUEUE_DEPTH
- enc_en  out  1  encoder enable
- enc_tha  out  48  head-of-queue tha to encoder
- enc_tpa  out  32  head-of-queue tpa to encoder
- app_req  in  1  application source wants TX path; level, held until granted
- app_gnt  out  1  application owns TX path
- app_done  in  1  one-cycle pulse, application frame finished
- tx_sel  out  1  TX mux select; 0 = ARP encoder, 1 = application
- tx_busy  out  1  high in any state except IDLE
- drop_cnt  out  16  saturating count of rejected requests

Behaviour:
- Reset (async assert, sync deassert) gives:
  - enc_en=0, enc_tha=0, enc_tpa=0
  - app_gnt=0, tx_sel=0, tx_busy=0, drop_cnt=0
  - queue empty, state IDLE, last_served=APP (ARP wins the first tie)
  - Reset mid-frame aborts immediately; no resume.
- Push:
  - arp_req_valid && arp_req_ready enqueues {tha,tpa}.
  - valid && !ready increments drop_cnt, saturating at 16'hFFFF.
  - Ready reflects registered count only; a pop in the same cycle does not make a full queue accept.
- enc_tha/enc_tpa are registered copies of the queue head, updated when entering ARP_TX and held stable until the next ARP_TX.
- ARP_BEATS = 28 by default; 56 when SPEED_100M is defined.
- FSM:
  - IDLE:
    - Queue non-empty and app_req both pending: serve the requester not equal to last_served.
    - Only one pending: serve it.
    - ARP -> ARP_TX: set tx_sel=0 and latch head on the transition edge.
    - APP -> APP_TX: set app_gnt=1, tx_sel=1.
  - ARP_TX:
    - enc_en=1 for exactly ARP_BEATS consecutive cycles, counted by a beat counter.
    - On the final beat: pop the queue, set last_served=ARP, next state GAP, enc_en=0 the following cycle.
  - APP_TX:
    - app_gnt held high until app_done is sampled high.
    - Then app_gnt=0, last_served=APP, next state GAP.
    - app_done while not in APP_TX is ignored.
  - GAP:
    - IFG_CYCLES cycles with enc_en=0 and app_gnt=0, then IDLE.
    - Arbitration in IDLE takes one cycle, so the minimum spacing between frames is IFG_CYCLES+1.
- Requests keep queuing during ARP_TX, APP_TX and GAP.
- Pushes during the final ARP beat are accepted only if the queue was not full.
- tx_sel holds its last value in GAP and IDLE.

Optional Feature:
- Macro: ARP_DEDUP_EN.
- Defined:
  - An incoming valid request whose tpa equals the tpa of any occupied queue entry is accepted (ready unaffected) but not stored.
  - drop_cnt is not incremented.
  - The entry currently being transmitted counts as occupied until popped.
- Not defined:
  - Every accepted request is enqueued, including duplicates.

Decomposition:
- Shared package `arp_pkg`:
  - arp_req_t struct {tha[47:0], tpa[31:0]}
  - state enum {IDLE, ARP_TX, APP_TX, GAP}
  - ARP_BEATS constant, keyed on SPEED_100M
  - ARP field constants shared with arp_encode
- One sub-module, arp_req_fifo:
  - Parameterised circular buffer of arp_req_t.
  - Exposes full, empty, head, and, under ARP_DEDUP_EN, a tpa-match vector.
- Arbitration and FSM stay in the top.

Test Plan:
1. Single request tha=48'h0A0B0C0D0E0F, tpa=32'hC0A80001 -> enc_en high exactly 28 consecutive cycles (56 with SPEED_100M), enc_tha/enc_tpa equal those values throughout; then 12 gap cycles, tx_busy falls.
2. Push 5 requests back-to-back with QUEUE_DEPTH=4 and no service -> 4 accepted, arp_req_ready low on the 5th, drop_cnt=1.
3. app_req and queued ARP request asserted together from reset -> ARP served first; next tie served to APP; alternation continues; app_gnt and enc_en never high together.
4. App frame with app_done after 100 cycles -> app_gnt high 100 cycles, tx_sel=1; stray app_done during ARP_TX has no effect.
5. Assert rst_n=0 at beat 10 of an ARP reply -> enc_en drops immediately, queue empty, drop_cnt=0, state IDLE after release.
6. ARP_DEDUP_EN: push tpa=32'hC0A80005 twice while the first is pending -> one reply transmitted, drop_cnt=0; without the macro, two replies.
